ddr_cmd_splitter: RTL and testbench
===================================

DDR_CMD_SPLITTER -- requirements
Module: ddr_cmd_splitter

Interface
REQ-001 SHALL provide parameters: ADDR_W, default 30, DDR address width; DATA_W, default 256, beat width; LEN_W, default 16, burst-count width.
REQ-002 clk  in  1  clock; all logic on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 phy_init_done  in  1  memory ready; requests blocked while low.
REQ-005 req_valid / req_ready  in / out  1 / 1  transfer request handshake.
REQ-006 req_wr  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  ADDR_W  start address; one burst spans 8 address units.
REQ-008 req_len  in  LEN_W  number of 2-beat bursts.
REQ-009 uw_valid / uw_ready / uw_data  in / out / in  1 / 1 / DATA_W  user write-beat stream.
REQ-010 ur_valid / ur_data  out / out  1 / DATA_W  user read-beat stream; no backpressure.
REQ-011 done  out  1  one-cycle pulse at transfer completion.
REQ-012 waddr_fifo_wr_en / waddr_fifo_din / waddr_fifo_full  out / out / in  1 / ADDR_W / 1.
REQ-013 wdata_fifo_wr_en / wdata_fifo_din / wdata_fifo_full  out / out / in  1 / DATA_W / 1.
REQ-014 raddr_fifo_wr_en / raddr_fifo_din / raddr_fifo_full  out / out / in  1 / ADDR_W / 1.
REQ-015 rdata_fifo_rd_en / rdata_fifo_dout / rdata_fifo_empty / rdata_fifo_valid  out / in / in / in  1 / DATA_W / 1 / 1; valid asserted the cycle after rd_en.

Function
REQ-016 FSM states SHALL be IDLE, WR_D0, WR_D1, WR_A, RD_ISSUE, RD_DRAIN, DONE.
REQ-017 req_ready SHALL be 1 only in IDLE with phy_init_done=1; request accepted when req_valid&req_ready; addr and len latched.
REQ-018 IDLE -> WR_D0 (req_wr=1) or RD_ISSUE (req_wr=0); len=0 -> DONE directly.
REQ-019 WR_D0/WR_D1: uw_ready = ~wdata_fifo_full; each uw handshake drives wdata_fifo_wr_en=1, din=uw_data that cycle; advance on handshake.
REQ-020 WR_A: waddr_fifo_wr_en=1 with current burst address when ~waddr_fifo_full; address += 8, remaining -= 1; remaining 0 -> DONE else WR_D0.
REQ-021 Data beats of a burst SHALL precede its address, so downstream never sees an address without two buffered beats.
REQ-022 RD_ISSUE: one raddr push per cycle while ~raddr_fifo_full; address += 8 per push; after last push -> RD_DRAIN.
REQ-023 rdata_fifo_rd_en = ~rdata_fifo_empty in RD_ISSUE and RD_DRAIN; ur_valid/ur_data = rdata_fifo_valid/dout registered one cycle.
REQ-024 Returned-beat counter (LEN_W+1 bits) SHALL count rdata_fifo_valid; reaching 2*len -> DONE.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE.
REQ-026 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-027 FIFO full mid-burst SHALL stall the state with no push and no data loss.

Reset
REQ-028 rst_n low SHALL force IDLE, clear counters and latched request, drive all outputs 0 (req_ready, uw_ready, ur_valid, done, all wr_en/rd_en, din buses).
REQ-029 Reset mid-transfer SHALL abandon it with no done pulse; FIFO contents untouched.

Configuration
REQ-030 Macro DDR_CMD_ADDR_CHK_EN: when defined, request with req_addr[2:0]!=0 or req_len=0 SHALL be accepted, produce no FIFO traffic, pulse err output (1 bit, registered) one cycle after acceptance, no done; when undefined, err is absent, req_addr[2:0] masked to 0 and len=0 completes via DONE.

Structure
REQ-031 Package ddr_cmd_pkg SHALL hold state enum, BURST_BEATS=2, ADDR_STEP=8, default widths.
REQ-032 Sub-module ddr_rd_return_cnt SHALL implement the returned-beat counter and compare.

Verification
REQ-033 Write addr=0x100, len=2, FIFOs never full -> wdata pushes D0..D3, waddr pushes 0x100 then 0x108, one done.
REQ-034 Read addr=0x40, len=3 with DDR model responding -> raddr 0x40,0x48,0x50; 6 ur_valid beats in order; done after 6th.
REQ-035 waddr_fifo_full held 5 cycles in WR_A -> no push, no state change; push on release.
REQ-036 addr=0x3FFFFFF8, len=2 -> second burst address 0x00000000.
REQ-037 rst_n low during RD_DRAIN -> IDLE, all outputs 0, no done; new request accepted afterwards.
REQ-038 DDR_CMD_ADDR_CHK_EN defined, addr=0x104 -> err pulse, zero FIFO pushes; undefined -> treated as 0x100.

Source files
------------

// File: rtl/ddr_cmd_pkg.sv
// rtl/ddr_cmd_pkg.sv - shared state encoding, burst geometry and default widths for the DDR command splitter
package ddr_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_D0,
    WR_D1,
    WR_A,
    RD_ISSUE,
    RD_DRAIN,
    DONE
  } state_t;

  localparam int BURST_BEATS = 2;
  localparam int ADDR_STEP   = 8;

  localparam int DEF_ADDR_W  = 30;
  localparam int DEF_DATA_W  = 256;
  localparam int DEF_LEN_W   = 16;

endpackage

// File: rtl/ddr_rd_return_cnt.sv
// rtl/ddr_rd_return_cnt.sv - counts read beats returned by the DDR side and flags when the transfer is complete
module ddr_rd_return_cnt
  import ddr_cmd_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           inc,
  input  logic [LEN_W:0] target,
  output logic           reached
);

  logic [LEN_W:0] cnt_q;

  // Restart at every accepted request, then advance once per returned beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + (LEN_W + 1)'(1);
    end
  end

  assign reached = (cnt_q == target);

endmodule

// File: rtl/ddr_cmd_splitter.sv
// rtl/ddr_cmd_splitter.sv - splits a transfer into 2-beat DDR bursts; DDR_CMD_ADDR_CHK_EN adds err for misaligned or empty requests
module ddr_cmd_splitter
  import ddr_cmd_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              phy_init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              uw_valid,
  output logic              uw_ready,
  input  logic [DATA_W-1:0] uw_data,
  output logic              ur_valid,
  output logic [DATA_W-1:0] ur_data,
  output logic              done,
`ifdef DDR_CMD_ADDR_CHK_EN
  output logic              err,
`endif
  output logic              waddr_fifo_wr_en,
  output logic [ADDR_W-1:0] waddr_fifo_din,
  input  logic              waddr_fifo_full,
  output logic              wdata_fifo_wr_en,
  output logic [DATA_W-1:0] wdata_fifo_din,
  input  logic              wdata_fifo_full,
  output logic              raddr_fifo_wr_en,
  output logic [ADDR_W-1:0] raddr_fifo_din,
  input  logic              raddr_fifo_full,
  output logic              rdata_fifo_rd_en,
  input  logic [DATA_W-1:0] rdata_fifo_dout,
  input  logic              rdata_fifo_empty,
  input  logic              rdata_fifo_valid
);

  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(ADDR_STEP - 1);

  state_t            state_q, state_d;
  logic              run_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [LEN_W-1:0]  len_q;
  logic              accept;
  logic              step;
  logic              bad;
  logic              last_burst;
  logic              rd_phase;
  logic              reached;
  logic [LEN_W:0]    target;

  assign last_burst = (rem_q == LEN_W'(1));
  assign rd_phase   = (state_q == RD_ISSUE) || (state_q == RD_DRAIN);
  assign target     = (LEN_W + 1)'(len_q) * (LEN_W + 1)'(BURST_BEATS);

`ifdef DDR_CMD_ADDR_CHK_EN
  assign bad = (req_addr[2:0] != 3'b000) || (req_len == '0);

  // Rejected requests are reported one cycle after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= accept & bad;
  end
`else
  assign bad = 1'b0;
`endif

  // Holds req_ready low until the first clock after reset is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and per-state handshake/push strobes
  always_comb begin
    state_d          = state_q;
    req_ready        = 1'b0;
    uw_ready         = 1'b0;
    wdata_fifo_wr_en = 1'b0;
    waddr_fifo_wr_en = 1'b0;
    raddr_fifo_wr_en = 1'b0;
    rdata_fifo_rd_en = 1'b0;
    done             = 1'b0;
    accept           = 1'b0;
    step             = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = run_q & phy_init_done;
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (bad)                state_d = IDLE;
          else if (req_len == '0) state_d = DONE;
          else if (req_wr)        state_d = WR_D0;
          else                    state_d = RD_ISSUE;
        end
      end
      WR_D0, WR_D1: begin
        uw_ready = ~wdata_fifo_full;
        if (uw_valid && !wdata_fifo_full) begin
          wdata_fifo_wr_en = 1'b1;
          state_d          = (state_q == WR_D0) ? WR_D1 : WR_A;
        end
      end
      WR_A: begin
        // Address goes out only after both beats of its burst are queued
        if (!waddr_fifo_full) begin
          waddr_fifo_wr_en = 1'b1;
          step             = 1'b1;
          state_d          = last_burst ? DONE : WR_D0;
        end
      end
      RD_ISSUE: begin
        rdata_fifo_rd_en = ~rdata_fifo_empty & ~reached;
        if (!raddr_fifo_full) begin
          raddr_fifo_wr_en = 1'b1;
          step             = 1'b1;
          if (last_burst) state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        rdata_fifo_rd_en = ~rdata_fifo_empty & ~reached;
        if (reached) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wdata_fifo_din = wdata_fifo_wr_en ? uw_data : '0;
  assign waddr_fifo_din = waddr_fifo_wr_en ? addr_q  : '0;
  assign raddr_fifo_din = raddr_fifo_wr_en ? addr_q  : '0;

  // Latch the request, then walk the burst address (wrapping) and remaining count per push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
      len_q  <= '0;
    end else if (accept) begin
      addr_q <= req_addr & ADDR_MASK;
      rem_q  <= req_len;
      len_q  <= req_len;
    end else if (step) begin
      addr_q <= addr_q + ADDR_W'(ADDR_STEP);
      rem_q  <= rem_q - LEN_W'(1);
    end
  end

  // Read beats are forwarded to the user one cycle after the FIFO presents them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ur_valid <= 1'b0;
      ur_data  <= '0;
    end else begin
      ur_valid <= rdata_fifo_valid;
      ur_data  <= rdata_fifo_dout;
    end
  end

  ddr_rd_return_cnt #(
    .LEN_W (LEN_W)
  ) u_rd_return_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .inc     (rdata_fifo_valid & rd_phase),
    .target  (target),
    .reached (reached)
  );

endmodule

// File: tb/tb_ddr_cmd_splitter.sv
// tb/tb_ddr_cmd_splitter.sv - scoreboard bench for ddr_cmd_splitter with a simple DDR read-return model
module tb_ddr_cmd_splitter;

  localparam int AW = 30;
  localparam int DW = 256;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          phy_init_done;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          uw_valid;
  logic          uw_ready;
  logic [DW-1:0] uw_data;
  logic          ur_valid;
  logic [DW-1:0] ur_data;
  logic          done;
`ifdef DDR_CMD_ADDR_CHK_EN
  logic          err;
`endif
  logic          waddr_fifo_wr_en;
  logic [AW-1:0] waddr_fifo_din;
  logic          waddr_fifo_full;
  logic          wdata_fifo_wr_en;
  logic [DW-1:0] wdata_fifo_din;
  logic          wdata_fifo_full;
  logic          raddr_fifo_wr_en;
  logic [AW-1:0] raddr_fifo_din;
  logic          raddr_fifo_full;
  logic          rdata_fifo_rd_en;
  logic [DW-1:0] rdata_fifo_dout  = '0;
  logic          rdata_fifo_empty = 1'b1;
  logic          rdata_fifo_valid = 1'b0;

  always #5 clk = ~clk;

  ddr_cmd_splitter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .phy_init_done    (phy_init_done),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_wr           (req_wr),
    .req_addr         (req_addr),
    .req_len          (req_len),
    .uw_valid         (uw_valid),
    .uw_ready         (uw_ready),
    .uw_data          (uw_data),
    .ur_valid         (ur_valid),
    .ur_data          (ur_data),
    .done             (done),
`ifdef DDR_CMD_ADDR_CHK_EN
    .err              (err),
`endif
    .waddr_fifo_wr_en (waddr_fifo_wr_en),
    .waddr_fifo_din   (waddr_fifo_din),
    .waddr_fifo_full  (waddr_fifo_full),
    .wdata_fifo_wr_en (wdata_fifo_wr_en),
    .wdata_fifo_din   (wdata_fifo_din),
    .wdata_fifo_full  (wdata_fifo_full),
    .raddr_fifo_wr_en (raddr_fifo_wr_en),
    .raddr_fifo_din   (raddr_fifo_din),
    .raddr_fifo_full  (raddr_fifo_full),
    .rdata_fifo_rd_en (rdata_fifo_rd_en),
    .rdata_fifo_dout  (rdata_fifo_dout),
    .rdata_fifo_empty (rdata_fifo_empty),
    .rdata_fifo_valid (rdata_fifo_valid)
  );

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int n_push   = 0;
  int beats_since = 0;
  int exp_done = 0;
  logic ddr_hold = 1'b0;

  logic [DW-1:0] exp_wd[$];
  logic [AW-1:0] exp_wa[$];
  logic [AW-1:0] exp_ra[$];
  logic [DW-1:0] exp_ur[$];
  logic [DW-1:0] rq[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int b);
    return {160'hC0FFEE, 32'(a), 32'(b), 32'hA5A55A5A};
  endfunction

  function automatic logic [DW-1:0] wr_data(input int i);
    return {192'hD00D, 32'hBEEF0000, 32'(i)};
  endfunction

  // DDR model: each raddr push returns two beats; a pop shows valid the next cycle
  always @(posedge clk) begin
    rdata_fifo_valid <= 1'b0;
    if (rdata_fifo_rd_en && rq.size() > 0) begin
      rdata_fifo_dout  <= rq.pop_front();
      rdata_fifo_valid <= 1'b1;
    end
    if (raddr_fifo_wr_en && !ddr_hold) begin
      rq.push_back(beat_data(raddr_fifo_din, 0));
      rq.push_back(beat_data(raddr_fifo_din, 1));
    end
    rdata_fifo_empty <= (rq.size() == 0);
  end

  // Scoreboard: compare every push and every user read beat against expectations
  always @(negedge clk) begin
    if (rst_n) begin
      if (wdata_fifo_wr_en) begin
        n_push++;
        beats_since++;
        chk("wdata_nofull", DW'(wdata_fifo_full), '0);
        chk("wdata_expected", DW'(exp_wd.size() > 0), DW'(1));
        if (exp_wd.size() > 0) chk("wdata", wdata_fifo_din, exp_wd.pop_front());
      end
      if (waddr_fifo_wr_en) begin
        n_push++;
        chk("waddr_nofull", DW'(waddr_fifo_full), '0);
        chk("waddr_after_2_beats", DW'(beats_since), DW'(2));
        beats_since = 0;
        chk("waddr_expected", DW'(exp_wa.size() > 0), DW'(1));
        if (exp_wa.size() > 0) chk("waddr", DW'(waddr_fifo_din), DW'(exp_wa.pop_front()));
      end
      if (raddr_fifo_wr_en) begin
        n_push++;
        chk("raddr_nofull", DW'(raddr_fifo_full), '0);
        chk("raddr_expected", DW'(exp_ra.size() > 0), DW'(1));
        if (exp_ra.size() > 0) chk("raddr", DW'(raddr_fifo_din), DW'(exp_ra.pop_front()));
      end
      if (rdata_fifo_rd_en) chk("rd_en_nonempty", DW'(rdata_fifo_empty), '0);
      if (ur_valid) begin
        chk("ur_expected", DW'(exp_ur.size() > 0), DW'(1));
        if (exp_ur.size() > 0) chk("ur_data", ur_data, exp_ur.pop_front());
      end
      if (done) begin
        done_cnt++;
        chk("done_all_drained", DW'(exp_wd.size() + exp_wa.size() + exp_ra.size() + exp_ur.size()), '0);
      end
    end
  end

  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    logic hs;
    int n;
    hs = 1'b0;
    n  = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_len = l;
    while (!hs && n < 20) begin
      @(negedge clk); hs = req_ready;
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b0;
    chk("req_accepted", DW'(hs), DW'(1));
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    logic hs;
    int n;
    hs = 1'b0;
    n  = 0;
    exp_wd.push_back(d);
    uw_valid = 1'b1; uw_data = d;
    while (!hs && n < 50) begin
      @(negedge clk); hs = uw_ready;
      @(posedge clk); #1; n++;
    end
    uw_valid = 1'b0;
    chk("uw_handshake", DW'(hs), DW'(1));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt < exp_done && n < 200) begin
      @(posedge clk); #1; n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(tag, DW'(done_cnt), DW'(exp_done));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctrl"}, DW'({req_ready, uw_ready, ur_valid, done, waddr_fifo_wr_en,
                             wdata_fifo_wr_en, raddr_fifo_wr_en, rdata_fifo_rd_en}), '0);
    chk({tag, "_bus"}, DW'(waddr_fifo_din | raddr_fifo_din) | wdata_fifo_din | ur_data, '0);
  endtask

  initial begin
    rst_n = 1'b0; phy_init_done = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
    uw_valid = 1'b0; uw_data = '0;
    waddr_fifo_full = 1'b0; wdata_fifo_full = 1'b0; raddr_fifo_full = 1'b0;

    // Reset state, then phy_init_done gating
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("ready_blocked_no_phy", DW'(req_ready), '0);
    phy_init_done = 1'b1;
    @(negedge clk);
    chk("ready_idle", DW'(req_ready), DW'(1));
    @(posedge clk); #1;

    // Write 0x100 len 2
    exp_wa.push_back(AW'('h100)); exp_wa.push_back(AW'('h108));
    do_req(1'b1, AW'('h100), LW'(2));
    for (int i = 0; i < 4; i++) send_beat(wr_data(i));
    exp_done++;
    wait_done("write_done");

    // Read 0x40 len 3
    for (int i = 0; i < 3; i++) begin
      exp_ra.push_back(AW'('h40 + 8 * i));
      exp_ur.push_back(beat_data(AW'('h40 + 8 * i), 0));
      exp_ur.push_back(beat_data(AW'('h40 + 8 * i), 1));
    end
    do_req(1'b0, AW'('h40), LW'(3));
    exp_done++;
    wait_done("read_done");
    chk("read_ur_left", DW'(exp_ur.size()), '0);

    // Data FIFO full stalls WR_D0, address FIFO full stalls WR_A for 5 cycles
    exp_wa.push_back(AW'('h200));
    wdata_fifo_full = 1'b1;
    do_req(1'b1, AW'('h200), LW'(1));
    repeat (3) begin
      @(negedge clk);
      chk("wd_full_uw_ready", DW'({uw_ready, wdata_fifo_wr_en}), '0);
      @(posedge clk); #1;
    end
    wdata_fifo_full = 1'b0;
    waddr_fifo_full = 1'b1;
    send_beat(wr_data(10));
    send_beat(wr_data(11));
    repeat (5) begin
      @(negedge clk);
      chk("wa_full_stall", DW'({waddr_fifo_wr_en, done, uw_ready, req_ready}), '0);
      @(posedge clk); #1;
    end
    chk("wa_full_pending", DW'(exp_wa.size()), DW'(1));
    waddr_fifo_full = 1'b0;
    exp_done++;
    wait_done("wa_full_done");

    // Address wrap at the top of the space
    exp_wa.push_back(AW'('h3FFFFFF8)); exp_wa.push_back(AW'(0));
    do_req(1'b1, AW'('h3FFFFFF8), LW'(2));
    for (int i = 20; i < 24; i++) send_beat(wr_data(i));
    exp_done++;
    wait_done("wrap_done");

    // Reset while waiting in RD_DRAIN
    ddr_hold = 1'b1;
    exp_ra.push_back(AW'('h80)); exp_ra.push_back(AW'('h88));
    do_req(1'b0, AW'('h80), LW'(2));
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    chk("drain_busy", DW'({req_ready, exp_ra.size() == 0}), DW'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_quiet("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    ddr_hold = 1'b0;
    rq.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_no_done", DW'(done_cnt), DW'(exp_done));
    exp_ra.push_back(AW'('h40));
    exp_ur.push_back(beat_data(AW'('h40), 0));
    exp_ur.push_back(beat_data(AW'('h40), 1));
    do_req(1'b0, AW'('h40), LW'(1));
    exp_done++;
    wait_done("post_reset_read_done");

`ifdef DDR_CMD_ADDR_CHK_EN
    // Misaligned and empty requests are rejected with err
    begin
      int pushes;
      pushes = n_push;
      do_req(1'b1, AW'('h104), LW'(1));
      @(negedge clk);
      chk("err_misaligned", DW'(err), DW'(1));
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_one_cycle", DW'(err), '0);
      do_req(1'b0, AW'('h100), LW'(0));
      @(negedge clk);
      chk("err_len0", DW'(err), DW'(1));
      repeat (4) @(posedge clk);
      #1;
      chk("err_no_push", DW'(n_push), DW'(pushes));
      chk("err_no_done", DW'(done_cnt), DW'(exp_done));
    end
`else
    // Misaligned address is masked to the burst boundary
    exp_wa.push_back(AW'('h100));
    do_req(1'b1, AW'('h104), LW'(1));
    send_beat(wr_data(30));
    send_beat(wr_data(31));
    exp_done++;
    wait_done("masked_done");

    // len 0 completes through DONE without touching the FIFOs
    begin
      int pushes;
      pushes = n_push;
      do_req(1'b1, AW'('h300), LW'(0));
      exp_done++;
      wait_done("len0_done");
      chk("len0_no_push", DW'(n_push), DW'(pushes));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
